// File: rtl/handshake_rx.sv
// Four-phase Req/Ack receiver: synchronises Req, captures din into a show-ahead FIFO,
// and withholds Ack while the FIFO is full. Define HANDSHAKE_RX_XFER_CNT_EN to add xfer_count.
module handshake_rx #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Req,
  input  logic [WIDTH-1:0] din,
  output logic             Ack,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             full
`ifdef HANDSHAKE_RX_XFER_CNT_EN
  ,
  output logic [15:0]      xfer_count
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StWaitRel = 2'd1
  } state_e;

  state_e              state_q, state_d;
  logic                ack_q, ack_d;
  logic                req_s1_q, req_s2_q;
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]     count_q, count_d;
  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic                wr_en;
  logic                rd_en;

  // Two-flop synchroniser; din bypasses it because it is stable while Req is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_s1_q <= 1'b0;
      req_s2_q <= 1'b0;
    end else begin
      req_s1_q <= Req;
      req_s2_q <= req_s1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    wr_en   = 1'b0;
    case (state_q)
      StIdle: begin
        ack_d = 1'b0;
        // Eligibility uses the registered count, so a same-cycle read cannot free a slot.
        if (req_s2_q && !full) begin
          wr_en   = 1'b1;
          ack_d   = 1'b1;
          state_d = StWaitRel;
        end
      end
      StWaitRel: begin
        ack_d = 1'b1;
        if (!req_s2_q) begin
          ack_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        ack_d   = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
    end
  end

  assign rd_en = dout_valid && dout_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign Ack        = ack_q;
  assign dout_valid = (count_q != '0);
  assign full       = (count_q == DepthCnt);
  assign dout       = dout_valid ? mem_q[rd_ptr_q] : '0;

`ifdef HANDSHAKE_RX_XFER_CNT_EN
  logic [15:0] xfer_count_q, xfer_count_d;

  always_comb begin
    xfer_count_d = xfer_count_q;
    if (wr_en) begin
      xfer_count_d = xfer_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_count_q <= 16'd0;
    end else begin
      xfer_count_q <= xfer_count_d;
    end
  end

  assign xfer_count = xfer_count_q;
`endif

endmodule

// File: tb/tb_handshake_rx.sv
// Bench for handshake_rx: directed handshake scenarios checked against a queue-based
// transaction model; covers xfer_count when HANDSHAKE_RX_XFER_CNT_EN is defined.
module tb_handshake_rx;

  localparam int unsigned WIDTH = 12;
  localparam int unsigned DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             Req = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             Ack;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready = 1'b0;
  logic             full;
`ifdef HANDSHAKE_RX_XFER_CNT_EN
  logic [15:0]      xfer_count;
`endif

  handshake_rx #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .Req       (Req),
    .din       (din),
    .Ack       (Ack),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .full      (full)
`ifdef HANDSHAKE_RX_XFER_CNT_EN
    ,
    .xfer_count(xfer_count)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Transaction model: Req delayed two edges, an "acked" phase flag, and a word queue.
  bit               rq_d1 = 1'b0;
  bit               rq_d2 = 1'b0;
  bit               m_ack = 1'b0;
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] seen[$];
  int               rdy_mode = 0;  // 0 low, 1 high, 2 random, 3 read only when a write lands
  logic [15:0]      m_xfer = 16'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit               rd;
    bit               wr;
    bit               ack_n;
    bit               r;
    bit               rs;
    logic [WIDTH-1:0] w;
    if (rdy_mode == 2) dout_ready = 1'($urandom_range(0, 1));
    else if (rdy_mode == 3) dout_ready = rq_d2 && !m_ack && (q.size() < DEPTH);
    else dout_ready = (rdy_mode == 1);
    rd    = dout_ready && (q.size() != 0);
    wr    = rq_d2 && !m_ack && (q.size() < DEPTH);
    ack_n = m_ack ? rq_d2 : wr;
    w     = din;
    r     = Req;
    rs    = rst;
    if (dout_valid && dout_ready) seen.push_back(dout);
    @(posedge clk);
    if (rs) begin
      q.delete();
      rq_d1  = 1'b0;
      rq_d2  = 1'b0;
      m_ack  = 1'b0;
      m_xfer = 16'd0;
    end else begin
      if (rd) void'(q.pop_front());
      if (wr) begin
        q.push_back(w);
        m_xfer = m_xfer + 16'd1;
      end
      rq_d2 = rq_d1;
      rq_d1 = r;
      m_ack = ack_n;
    end
    #1;
    check("ack", 32'(Ack), 32'(m_ack));
    check("valid", 32'(dout_valid), 32'(q.size() != 0));
    check("full", 32'(full), 32'(q.size() == DEPTH));
    check("dout", 32'(dout), (q.size() != 0) ? 32'(q[0]) : 32'd0);
`ifdef HANDSHAKE_RX_XFER_CNT_EN
    check("xfer_count", 32'(xfer_count), 32'(m_xfer));
`endif
  endtask

  task automatic send(input logic [WIDTH-1:0] w);
    int n;
    din = w;
    Req = 1'b1;
    n   = 0;
    while (Ack !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check("ack_rise_bound", 32'(n < 40), 32'd1);
    Req = 1'b0;
    n   = 0;
    while (Ack !== 1'b0 && n < 40) begin
      step();
      n++;
    end
    check("ack_fall_bound", 32'(n < 40), 32'd1);
  endtask

  initial begin
    int n;
    #1;
    step();
    step();
    rst = 1'b0;
    check("rst_ack", 32'(Ack), 32'd0);
    check("rst_valid", 32'(dout_valid), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    step();

    // 1: single transfer latency
    rdy_mode = 0;
    din = 12'hABC;
    Req = 1'b1;
    step();
    check("t1_ack_n0", 32'(Ack), 32'd0);
    step();
    check("t1_ack_n1", 32'(Ack), 32'd0);
    check("t1_valid_n1", 32'(dout_valid), 32'd0);
    step();
    check("t1_ack_n2", 32'(Ack), 32'd1);
    check("t1_valid_n2", 32'(dout_valid), 32'd1);
    check("t1_dout_n2", 32'(dout), 32'hABC);
    Req = 1'b0;
    step();
    step();
    check("t1_ack_m1", 32'(Ack), 32'd1);
    step();
    check("t1_ack_m2", 32'(Ack), 32'd0);
    rdy_mode = 1;
    step();
    check("t1_one_entry", 32'(dout_valid), 32'd0);

    // 2: back-pressure
    rdy_mode = 0;
    for (int i = 1; i <= 4; i++) send(WIDTH'(i));
    check("t2_full", 32'(full), 32'd1);
    din = 12'd5;
    Req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("t2_ack_held", 32'(Ack), 32'd0);
    end
    rdy_mode = 1;
    step();
    rdy_mode = 0;
    check("t2_ack_after_read", 32'(Ack), 32'd0);
    step();
    check("t2_ack_next", 32'(Ack), 32'd1);
    Req = 1'b0;
    n = 0;
    while (Ack !== 1'b0 && n < 40) begin
      step();
      n++;
    end
    check("t2_ack_fall_bound", 32'(n < 40), 32'd1);
    rdy_mode = 1;
    for (int i = 0; i < 4; i++) begin
      check("t2_drain", 32'(dout), 32'(i + 2));
      step();
    end
    check("t2_empty", 32'(dout_valid), 32'd0);

    // 3: streaming with dout_ready held high
    seen.delete();
    rdy_mode = 1;
    for (int i = 0; i < 8; i++) send(WIDTH'(12'h100 + i));
    step();
    check("t3_count", 32'(seen.size()), 32'd8);
    for (int i = 0; i < 8 && i < seen.size(); i++) begin
      check("t3_order", 32'(seen[i]), 32'(12'h100 + i));
    end

    // 4: three entries held, reads coincide with writes across pointer wrap
    rdy_mode = 0;
    for (int i = 0; i < 3; i++) send(WIDTH'($urandom));
    rdy_mode = 3;
    for (int i = 0; i < 10; i++) begin
      send(WIDTH'($urandom));
      check("t4_occupied", 32'(dout_valid && !full), 32'd1);
    end
    rdy_mode = 1;
    for (int i = 0; i < 4; i++) step();
    check("t4_drained", 32'(dout_valid), 32'd0);

    // 5: reset during WAIT_REL with words buffered
    rdy_mode = 0;
    send(WIDTH'($urandom));
    send(WIDTH'($urandom));
    din = WIDTH'($urandom);
    Req = 1'b1;
    n = 0;
    while (Ack !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check("t5_ack_bound", 32'(n < 40), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_rst_ack", 32'(Ack), 32'd0);
    check("t5_rst_valid", 32'(dout_valid), 32'd0);
    step();
    check("t5_ack_r1", 32'(Ack), 32'd0);
    step();
    check("t5_ack_r2", 32'(Ack), 32'd0);
    step();
    check("t5_ack_r3", 32'(Ack), 32'd1);
    for (int i = 0; i < 4; i++) step();
    Req = 1'b0;
    n = 0;
    while (Ack !== 1'b0 && n < 40) begin
      step();
      n++;
    end
    check("t5_fall_bound", 32'(n < 40), 32'd1);
    rdy_mode = 1;
    step();
    check("t5_one_entry", 32'(dout_valid), 32'd0);

    // Random traffic with random consumer
    rdy_mode = 2;
    for (int i = 0; i < 20; i++) begin
      send(WIDTH'($urandom));
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) step();
    end
    rdy_mode = 1;
    for (int i = 0; i < 6; i++) step();

`ifdef HANDSHAKE_RX_XFER_CNT_EN
    // 6: counter wrap via preload
    rdy_mode = 1;
    force dut.xfer_count_q = 16'hFFFF;
    #1;
    release dut.xfer_count_q;
    m_xfer = 16'hFFFF;
    check("t6_preload", 32'(xfer_count), 32'hFFFF);
    send(WIDTH'($urandom));
    check("t6_wrap", 32'(xfer_count), 32'h0000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
